// File: rtl/mean9x9.sv
// rtl/mean9x9.sv - 9x9 box-mean filter over a raster grayscale stream
module mean9x9 #(
    parameter int IMAGE_WIDTH = 320
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        gray_valid,
    input  logic [7:0]  gray,
    output logic        mean_valid,
    output logic [7:0]  mean_out,
    output logic [15:0] center_row_s1,
    output logic [15:0] center_col_s1
);

    localparam int             CW       = $clog2(IMAGE_WIDTH);
    localparam logic [CW-1:0]  COL_LAST = CW'(IMAGE_WIDTH - 1);
    localparam logic [CW-1:0]  COL_MIN  = CW'(8);
    // floor((S + 40) / 81) == ((S + 40) * 25891) >> 21 for every S + 40 < 2^15
    localparam logic [14:0]    ROUND    = 15'd40;
    localparam logic [14:0]    RECIP    = 15'd25891;
    localparam int             SHIFT    = 21;

    // A pixel offered during reset is dropped.
    logic accept;
    assign accept = gray_valid & ~rst;

    logic [CW-1:0] col_q, col_d;
    logic [15:0]   row_q, row_d;

    // Raster position of the pixel currently on the input.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = row_q + 16'd1;
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    // Position counters; the row counter free-runs modulo 2^16 until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    // lb_q[k] holds row r-1-k; each accepted pixel pushes its column down one line.
    logic [7:0] lb_q [8][IMAGE_WIDTH];

    // Line-buffer cascade, stalled whenever no pixel is accepted.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb_q[0][col_q] <= gray;
            for (int k = 1; k < 8; k++) begin
                lb_q[k][col_q] <= lb_q[k-1][col_q];
            end
        end
    end

    logic [11:0] col_sum_d;

    // Sum of the nine vertically stacked pixels ending at the incoming one.
    always_comb begin
        col_sum_d = 12'(gray);
        for (int k = 0; k < 8; k++) begin
            col_sum_d = col_sum_d + 12'(lb_q[k][col_q]);
        end
    end

    // cs_q[i] is the column sum for column c-i; keeping sums instead of
    // pixels shrinks the window to nine 12-bit registers.
    logic [11:0] cs_q [9];

    // Column-sum shift register, stalled with the line buffers.
    always_ff @(posedge clk) begin
        if (accept) begin
            cs_q[0] <= col_sum_d;
            for (int i = 1; i < 9; i++) begin
                cs_q[i] <= cs_q[i-1];
            end
        end
    end

    logic        v1_q, v2_q, v3_q;
    logic [15:0] r1_q, r2_q, r3_q;
    logic [15:0] c1_q, c2_q, c3_q;
    logic [14:0] s2_q;
    logic [29:0] p3_q;
    logic        eligible;
    logic [14:0] win_sum_d;
    logic [7:0]  mean_d;

    // Borders never produce output, so stale buffer contents are never seen.
    assign eligible = accept && (row_q >= 16'd8) && (col_q >= COL_MIN);

    // Full 81-pixel window sum from the nine column sums.
    always_comb begin
        win_sum_d = '0;
        for (int i = 0; i < 9; i++) begin
            win_sum_d = win_sum_d + 15'(cs_q[i]);
        end
    end

    assign mean_d = 8'(p3_q >> SHIFT);

    // Output pipeline: window capture, sum, reciprocal multiply; runs every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
        end else begin
            v1_q <= eligible;
            v2_q <= v1_q;
            v3_q <= v2_q;
        end
        r1_q <= row_q - 16'd4;
        c1_q <= 16'(col_q) - 16'd4;
        r2_q <= r1_q;
        c2_q <= c1_q;
        s2_q <= win_sum_d;
        r3_q <= r2_q;
        c3_q <= c2_q;
        p3_q <= 30'(s2_q + ROUND) * 30'(RECIP);
    end

    // Output registers; data and centre hold between valid pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            mean_valid    <= 1'b0;
            mean_out      <= 8'd0;
            center_row_s1 <= 16'd0;
            center_col_s1 <= 16'd0;
        end else begin
            mean_valid <= v3_q;
            if (v3_q) begin
                mean_out      <= mean_d;
                center_row_s1 <= r3_q;
                center_col_s1 <= c3_q;
            end
        end
    end

endmodule

// File: tb/tb_mean9x9.sv
// tb/tb_mean9x9.sv - directed self-checking bench for mean9x9
module tb_mean9x9;

    localparam int W = 320;

    logic        clk = 1'b0;
    logic        rst;
    logic        gray_valid;
    logic [7:0]  gray;
    logic        mean_valid;
    logic [7:0]  mean_out;
    logic [15:0] center_row_s1;
    logic [15:0] center_col_s1;

    mean9x9 #(.IMAGE_WIDTH(W)) dut (
        .clk           (clk),
        .rst           (rst),
        .gray_valid    (gray_valid),
        .gray          (gray),
        .mean_valid    (mean_valid),
        .mean_out      (mean_out),
        .center_row_s1 (center_row_s1),
        .center_col_s1 (center_col_s1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int row;
        int col;
        int val;
    } out_t;
    out_t oq[$];

    always @(negedge clk) begin
        if (mean_valid === 1'b1)
            oq.push_back('{cyc, int'(center_row_s1), int'(center_col_s1), int'(mean_out)});
    end

    int n_cmp = 0;
    int n_bad = 0;

    initial begin
        #3000000;
        $display("FAIL watchdog: got time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [7:0] pix(input int mode, input int base, input int r, input int c,
                                       input int sr, input int sc, input int sv);
        if (r == sr && c == sc) return 8'(sv);
        if (mode == 1) return 8'(c % 256);
        return 8'(base);
    endfunction

    task automatic send(input logic [7:0] v, input int gap, output int acc);
        gray       = v;
        gray_valid = 1'b1;
        @(posedge clk); #1;
        acc        = cyc;
        gray_valid = 1'b0;
        repeat (gap - 1) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic feed_frame(input int mode, input int base, input int rows, input int gap,
                              input int sr, input int sc, input int sv, output int acc88);
        int acc;
        acc88 = -1;
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < W; c++) begin
                send(pix(mode, base, r, c, sr, sc, sv), gap, acc);
                if (r == 8 && c == 8) acc88 = acc;
            end
        end
    endtask

    task automatic drain();
        gray_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst        = 1'b1;
        gray_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        gray_valid = 1'b1;
        gray       = 8'hAA;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (mean_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %0b required 0", mean_valid); end
        n_cmp++; if (mean_out !== 8'd0) begin n_bad++; $display("FAIL reset_mean: got %0d required 0", mean_out); end
        n_cmp++; if (center_row_s1 !== 16'd0) begin n_bad++; $display("FAIL reset_row: got %0d required 0", center_row_s1); end
        n_cmp++; if (center_col_s1 !== 16'd0) begin n_bad++; $display("FAIL reset_col: got %0d required 0", center_col_s1); end
        rst        = 1'b0;
        gray_valid = 1'b0;
    endtask

    // Constant 100, one pixel every 11 cycles, 10 rows -> 312 x 2 outputs.
    task automatic test_constant();
        int acc88, bad, first;
        oq.delete();
        feed_frame(0, 100, 10, 11, -1, -1, 0, acc88);
        drain();
        repeat (10) @(posedge clk);
        #1;
        n_cmp++; if (oq.size() != 624) begin n_bad++; $display("FAIL const_count: got %0d required 624", oq.size()); end
        bad = 0;
        for (int i = 0; i < oq.size(); i++) begin
            if (oq[i].val != 100 || oq[i].row != 4 + i / 312 || oq[i].col != 4 + i % 312) bad++;
        end
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL const_values: got %0d bad outputs required 0", bad); end
        first = (oq.size() > 0) ? oq[0].cyc : -1;
        n_cmp++; if (first != acc88 + 3) begin n_bad++; $display("FAIL const_latency: got cycle %0d required %0d", first, acc88 + 3); end
        first = (oq.size() > 0) ? oq[0].row * 65536 + oq[0].col : -1;
        n_cmp++; if (first != 4 * 65536 + 4) begin n_bad++; $display("FAIL const_first_centre: got %0d required %0d", first, 4 * 65536 + 4); end
        n_cmp++; if (mean_valid !== 1'b0 || mean_out !== 8'd100) begin n_bad++; $display("FAIL hold_mean: got valid %0b mean %0d required valid 0 mean 100", mean_valid, mean_out); end
        n_cmp++; if (center_row_s1 !== 16'd5 || center_col_s1 !== 16'd315) begin n_bad++; $display("FAIL hold_centre: got (%0d,%0d) required (5,315)", center_row_s1, center_col_s1); end
    endtask

    // 9-row frame of background bg with one spot at (4,100); only centre row 4 is reported.
    task automatic run_spot(input int sv, input int bg, input int hit, input int miss, input string name);
        int acc88, bad, got;
        do_reset(2);
        oq.delete();
        feed_frame(0, bg, 9, 1, 4, 100, sv, acc88);
        drain();
        n_cmp++; if (oq.size() != 312) begin n_bad++; $display("FAIL %s_count: got %0d required 312", name, oq.size()); end
        bad = 0;
        for (int i = 0; i < oq.size(); i++) begin
            if (oq[i].row != 4 || oq[i].col != 4 + i ||
                oq[i].val != ((oq[i].col >= 96 && oq[i].col <= 104) ? hit : miss)) bad++;
        end
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL %s_values: got %0d bad outputs required 0", name, bad); end
        got = (oq.size() > 96) ? oq[96].val : -1;
        n_cmp++; if (got != hit) begin n_bad++; $display("FAIL %s_centre100: got %0d required %0d", name, got, hit); end
    endtask

    task automatic test_rounding();
        run_spot(41, 0, 1, 0, "round_41");
        run_spot(40, 0, 0, 0, "round_40");
        run_spot(174, 255, 254, 255, "round_254");
        run_spot(255, 255, 255, 255, "all_255");
    endtask

    // Ramp image, gray_valid held high for 12 rows.
    task automatic test_back_to_back();
        int acc88, bad_order, bad_run, bad_val;
        do_reset(2);
        oq.delete();
        feed_frame(1, 0, 12, 1, -1, -1, 0, acc88);
        drain();
        n_cmp++; if (oq.size() != 1248) begin n_bad++; $display("FAIL b2b_count: got %0d required 1248", oq.size()); end
        bad_order = 0;
        bad_run   = 0;
        bad_val   = 0;
        for (int i = 0; i < oq.size(); i++) begin
            if (oq[i].row != 4 + i / 312 || oq[i].col != 4 + i % 312) bad_order++;
            if (i % 312 != 0 && oq[i].cyc != oq[i-1].cyc + 1) bad_run++;
            if (oq[i].col <= 251 && oq[i].val != oq[i].col) bad_val++;
        end
        n_cmp++; if (bad_order != 0) begin n_bad++; $display("FAIL b2b_order: got %0d bad centres required 0", bad_order); end
        n_cmp++; if (bad_run != 0) begin n_bad++; $display("FAIL b2b_consecutive: got %0d gaps required 0", bad_run); end
        n_cmp++; if (bad_val != 0) begin n_bad++; $display("FAIL ramp_values: got %0d bad means required 0", bad_val); end
    endtask

    // Reset while results are in flight, then a fresh frame.
    task automatic test_midframe_reset();
        int acc, acc88, rc, pre, post, bad, first;
        do_reset(2);
        oq.delete();
        feed_frame(0, 50, 8, 1, -1, -1, 0, acc88);
        for (int c = 0; c < 20; c++) send(8'd50, 1, acc);
        rst        = 1'b1;
        gray_valid = 1'b1;
        gray       = 8'd50;
        @(posedge clk); #1;
        rc         = cyc;
        rst        = 1'b0;
        gray_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        pre  = 0;
        post = 0;
        for (int i = 0; i < oq.size(); i++) begin
            if (oq[i].cyc < rc) pre++; else post++;
        end
        n_cmp++; if (pre != 9) begin n_bad++; $display("FAIL abort_pre_count: got %0d required 9", pre); end
        n_cmp++; if (post != 0) begin n_bad++; $display("FAIL abort_post_count: got %0d required 0", post); end
        oq.delete();
        feed_frame(0, 77, 9, 1, -1, -1, 0, acc88);
        drain();
        n_cmp++; if (oq.size() != 312) begin n_bad++; $display("FAIL fresh_count: got %0d required 312", oq.size()); end
        first = (oq.size() > 0) ? oq[0].cyc : -1;
        n_cmp++; if (first != acc88 + 3) begin n_bad++; $display("FAIL fresh_latency: got cycle %0d required %0d", first, acc88 + 3); end
        first = (oq.size() > 0) ? oq[0].row * 65536 + oq[0].col : -1;
        n_cmp++; if (first != 4 * 65536 + 4) begin n_bad++; $display("FAIL fresh_first_centre: got %0d required %0d", first, 4 * 65536 + 4); end
        bad = 0;
        for (int i = 0; i < oq.size(); i++) begin
            if (oq[i].val != 77 || oq[i].row != 4 || oq[i].col != 4 + i) bad++;
        end
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL fresh_values: got %0d bad outputs required 0", bad); end
    endtask

    initial begin
        rst        = 1'b1;
        gray_valid = 1'b0;
        gray       = 8'd0;
        test_reset();
        test_constant();
        test_rounding();
        test_back_to_back();
        test_midframe_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
